// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  head,
    output logic [CW-1:0] occ
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & (occ != '0);
    assign do_push = push & ((occ != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                occ <= occ + CW'(1);
            else if (do_pop && !do_push)
                occ <= occ - CW'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    always_comb begin
        head = '0;
        if (occ != '0)
            head = mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues one imem read per cycle, queues tagged words.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky fault that stops fetch.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter  logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter  int          IMEM_DEPTH = 16,
    parameter  int          QDEPTH     = 2,
    localparam int          AW         = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_pc,
    output logic [31:0]     id_instr,
    output logic            fault
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   pc_q;
    logic [31:0]   infl_pc;
    logic          infl;
    logic          epoch;
    logic          infl_epoch;
    logic          fault_q;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   demand;
    fetch_entry_t  head;
    fetch_entry_t  wdata;
    logic [CW-1:0] occ;

    assign id_valid = (occ != '0);
    assign pop      = id_valid & id_ready;

    // Slots already claimed by buffered and in-flight words, less the one leaving now.
    assign demand = (CW+1)'(occ) + (CW+1)'(infl) - (CW+1)'(pop);
    assign issue  = !reset && !halt && !redirect_valid && !fault_q
                    && (demand < (CW+1)'(QDEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc_q[AW+1:2];

    // A word from a request made before the last redirect carries a stale epoch.
    assign push        = infl & (infl_epoch == epoch);
    assign wdata.pc    = infl_pc;
    assign wdata.instr = imem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            infl       <= 1'b0;
            infl_pc    <= '0;
            epoch      <= 1'b0;
            infl_epoch <= 1'b0;
        end else begin
            infl <= issue;
            if (issue) begin
                infl_pc    <= pc_q;
                infl_epoch <= epoch;
            end
            if (redirect_valid) begin
                pc_q  <= {redirect_pc[31:2], 2'b00};
                epoch <= ~epoch;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fault_q <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            fault_q <= 1'b1;
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign fault_q         = 1'b0;
`endif

    assign fault = fault_q;

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .occ   (occ)
    );

    assign id_pc    = head.pc;
    assign id_instr = head.instr;

endmodule
